// File: rtl/pre_mant_aligner.sv
`default_nettype none
// ============================================================================
// Module   : pre_mant_aligner
// Purpose  : FP adder front-end. Unpacks two operands, inserts the hidden bit,
//            selects the larger effective exponent and right-aligns the
//            smaller operand's significand into a FIELD_W-bit field.
//            Two-stage pipeline with valid/ready flow control.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, in_a/in_b  {sign, exp, frac} operands
//            out_valid/out_ready           result handshake
//            out_sign_a/b, out_mant_a/b    signs and aligned magnitudes
//            out_exp_max                   larger effective exponent
// Options  : `define STICKY_EN to OR shifted-out bits into bit 0 of the
//            shifted field. Default build drops them.
// Revision : 1.0 - initial release
// ============================================================================
module pre_mant_aligner #(
    parameter int EXP_W   = 8,
    parameter int MANT_W  = 22,
    parameter int FIELD_W = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   in_a,
    input  logic [EXP_W+MANT_W:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign_a,
    output logic                    out_sign_b,
    output logic [FIELD_W-1:0]      out_mant_a,
    output logic [FIELD_W-1:0]      out_mant_b,
    output logic [EXP_W-1:0]        out_exp_max
);

    localparam int               c_op_w   = 1 + EXP_W + MANT_W;
    // Zero bits below the significand so the hidden bit lands at FIELD_W-2.
    localparam int               c_pad_lo = FIELD_W - 2 - MANT_W;
    localparam logic [EXP_W-1:0] c_exp_one = EXP_W'(1);

    // ------------------------------------------------------------------
    // Unpack
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]   w_exp_a, w_exp_b;
    logic [EXP_W-1:0]   w_eff_a, w_eff_b;
    logic [FIELD_W-1:0] w_field_a, w_field_b;
    logic               w_a_ge_b;

    assign w_exp_a = in_a[MANT_W +: EXP_W];
    assign w_exp_b = in_b[MANT_W +: EXP_W];

    // Zero exponent means denormal/zero: no hidden bit, effective exponent 1.
    assign w_eff_a = (w_exp_a == '0) ? c_exp_one : w_exp_a;
    assign w_eff_b = (w_exp_b == '0) ? c_exp_one : w_exp_b;

    // Bit FIELD_W-1 stays clear as carry headroom for the adder.
    assign w_field_a = {1'b0, (w_exp_a != '0), in_a[MANT_W-1:0], {c_pad_lo{1'b0}}};
    assign w_field_b = {1'b0, (w_exp_b != '0), in_b[MANT_W-1:0], {c_pad_lo{1'b0}}};

    assign w_a_ge_b = (w_eff_a >= w_eff_b);

    // ------------------------------------------------------------------
    // Flow control: each stage loads when empty or when the stage ahead
    // of it moves on, so a full pipe streams at one pair per cycle.
    // ------------------------------------------------------------------
    logic r1_valid, r2_valid;
    logic w_s2_load, w_s1_load;

    assign w_s2_load = ~r2_valid | out_ready;
    assign w_s1_load = ~r1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: unpacked operands, exponent max and difference
    // ------------------------------------------------------------------
    logic               r1_sign_a, r1_sign_b;
    logic [FIELD_W-1:0] r1_field_a, r1_field_b;
    logic [EXP_W-1:0]   r1_exp_max, r1_diff;
    logic               r1_sel_b;   // B is the operand to be shifted

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid   <= 1'b0;
            r1_sign_a  <= 1'b0;
            r1_sign_b  <= 1'b0;
            r1_field_a <= '0;
            r1_field_b <= '0;
            r1_exp_max <= '0;
            r1_diff    <= '0;
            r1_sel_b   <= 1'b0;
        end else if (w_s1_load) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_sign_a  <= in_a[c_op_w-1];
                r1_sign_b  <= in_b[c_op_w-1];
                r1_field_a <= w_field_a;
                r1_field_b <= w_field_b;
                r1_exp_max <= w_a_ge_b ? w_eff_a : w_eff_b;
                r1_diff    <= w_a_ge_b ? (w_eff_a - w_eff_b) : (w_eff_b - w_eff_a);
                // Equal exponents select B with a zero shift: no change.
                r1_sel_b   <= w_a_ge_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: align the smaller field
    // ------------------------------------------------------------------
    logic [FIELD_W-1:0] w_small, w_shift_raw, w_shifted;
    logic               w_shift_oor;

    assign w_small     = r1_sel_b ? r1_field_b : r1_field_a;
    assign w_shift_oor = (int'(r1_diff) >= FIELD_W);
    assign w_shift_raw = w_shift_oor ? '0 : (w_small >> r1_diff);

`ifdef STICKY_EN
    logic [FIELD_W-1:0] w_lost_mask;
    logic               w_sticky;

    // Mask of the low bits that fall off; all ones once the shift is
    // at least the field width.
    assign w_lost_mask = ~({FIELD_W{1'b1}} << r1_diff);
    assign w_sticky    = |(w_small & w_lost_mask);
    assign w_shifted   = {w_shift_raw[FIELD_W-1:1], w_shift_raw[0] | w_sticky};
`else
    assign w_shifted   = w_shift_raw;
`endif

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly). Lanes keep their
    // operand identity: mant_a always carries in_a.
    // ------------------------------------------------------------------
    logic               r2_sign_a, r2_sign_b;
    logic [FIELD_W-1:0] r2_mant_a, r2_mant_b;
    logic [EXP_W-1:0]   r2_exp_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid   <= 1'b0;
            r2_sign_a  <= 1'b0;
            r2_sign_b  <= 1'b0;
            r2_mant_a  <= '0;
            r2_mant_b  <= '0;
            r2_exp_max <= '0;
        end else if (w_s2_load) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign_a  <= r1_sign_a;
                r2_sign_b  <= r1_sign_b;
                r2_mant_a  <= r1_sel_b ? r1_field_a : w_shifted;
                r2_mant_b  <= r1_sel_b ? w_shifted  : r1_field_b;
                r2_exp_max <= r1_exp_max;
            end
        end
    end

    assign out_valid   = r2_valid;
    assign out_sign_a  = r2_sign_a;
    assign out_sign_b  = r2_sign_b;
    assign out_mant_a  = r2_mant_a;
    assign out_mant_b  = r2_mant_b;
    assign out_exp_max = r2_exp_max;

endmodule
`default_nettype wire

// File: tb/tb_pre_mant_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_pre_mant_aligner
// Purpose  : Self-checking bench for pre_mant_aligner. Expected results come
//            from a bit-serial alignment model, queued on input transfer and
//            compared on output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pre_mant_aligner;

    typedef struct packed {
        logic        sign_a;
        logic        sign_b;
        logic [49:0] mant_a;
        logic [49:0] mant_b;
        logic [7:0]  exp_max;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [30:0] in_a = '0;
    logic [30:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign_a, out_sign_b;
    logic [49:0] out_mant_a, out_mant_b;
    logic [7:0]  out_exp_max;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pre_mant_aligner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign_a (out_sign_a),
        .out_sign_b (out_sign_b),
        .out_mant_a (out_mant_a),
        .out_mant_b (out_mant_b),
        .out_exp_max(out_exp_max)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: place significands, then shift the smaller one right one
    // bit at a time, collecting lost bits.
    function automatic exp_t model(input logic [30:0] a, input logic [30:0] b);
        exp_t        r;
        int          ea, eb, d;
        logic [49:0] fa, fb, sm;
        logic        st;
        ea = (a[29:22] == 8'd0) ? 1 : int'(a[29:22]);
        eb = (b[29:22] == 8'd0) ? 1 : int'(b[29:22]);
        fa = 50'({(a[29:22] != 8'd0), a[21:0]}) << 26;
        fb = 50'({(b[29:22] != 8'd0), b[21:0]}) << 26;
        if (ea >= eb) begin d = ea - eb; sm = fb; end
        else          begin d = eb - ea; sm = fa; end
        st = 1'b0;
        for (int k = 0; k < d; k++) begin
            st = st | sm[0];
            sm = sm >> 1;
        end
`ifdef STICKY_EN
        sm[0] = sm[0] | st;
`endif
        r.sign_a = a[30];
        r.sign_b = b[30];
        if (ea >= eb) begin r.mant_a = fa; r.mant_b = sm; r.exp_max = 8'(ea); end
        else          begin r.mant_a = sm; r.mant_b = fb; r.exp_max = 8'(eb); end
        return r;
    endfunction

    function automatic logic [30:0] pk(input logic s, input logic [7:0] e, input logic [21:0] f);
        return {s, e, f};
    endfunction

    // Handshakes are stable at the falling edge and transfer on the next
    // rising edge; pop before push so a same-cycle pair stays ordered.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    check_value("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_value("sign_a",  64'(out_sign_a),  64'(e.sign_a));
                    check_value("sign_b",  64'(out_sign_b),  64'(e.sign_b));
                    check_value("mant_a",  64'(out_mant_a),  64'(e.mant_a));
                    check_value("mant_b",  64'(out_mant_b),  64'(e.mant_b));
                    check_value("exp_max", 64'(out_exp_max), 64'(e.exp_max));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [30:0] a, input logic [30:0] b);
        int   n;
        logic acc;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) check_value("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        check_value("drain_done", 64'(n < 50), 1);
    endtask

    initial begin
        exp_t e1;
        int   n0;

        // Reset state
        #2;
        check_value("rst_out_valid", 64'(out_valid), 0);
        check_value("rst_mant_a",    64'(out_mant_a), 0);
        check_value("rst_mant_b",    64'(out_mant_b), 0);
        check_value("rst_exp_max",   64'(out_exp_max), 0);
        check_value("rst_signs",     64'({out_sign_a, out_sign_b}), 0);
        tick();
        tick();
        rst_n = 1'b1;
        check_value("rst_in_ready", 64'(in_ready), 1);

        // Directed alignment cases
        out_ready = 1'b1;
        send(pk(0, 8'd130, 22'd0), pk(1, 8'd128, 22'd0));
        send(pk(0, 8'd0, 22'd1),   pk(0, 8'd0, 22'd1));
        send(pk(0, 8'd127, 22'd0), pk(0, 8'd100, 22'd0));
        send(pk(0, 8'd100, 22'd0), pk(0, 8'd127, 22'd0));
        send(pk(0, 8'd200, 22'd0), pk(0, 8'd100, 22'h3FFFFF));
        send(pk(0, 8'd148, 22'd0), pk(0, 8'd100, 22'd0));
        send(pk(0, 8'd149, 22'd0), pk(0, 8'd100, 22'd0));
        send(pk(1, 8'd255, 22'h155555), pk(0, 8'd0, 22'h2AAAAA));
        send(pk(0, 8'd1, 22'h00000F), pk(1, 8'd0, 22'h3FFFF0));
        send(pk(0, 8'd160, 22'h123456), pk(0, 8'd170, 22'h3ABCDE));
        for (int i = 0; i < 20; i++)
            send(31'($urandom()), {1'($urandom()), 8'($urandom_range(90, 170)), 22'($urandom())});
        drain();

        // Stall: two accepts fill the pipe, outputs held
        out_ready = 1'b0;
        send(pk(0, 8'd140, 22'h0ABCDE), pk(1, 8'd135, 22'h112233));
        e1 = model(pk(0, 8'd140, 22'h0ABCDE), pk(1, 8'd135, 22'h112233));
        check_value("stall_in_ready_1", 64'(in_ready), 1);
        send(pk(1, 8'd90, 22'h3F0F0F), pk(0, 8'd120, 22'h00FF00));
        check_value("stall_in_ready_2", 64'(in_ready), 0);
        in_a = pk(0, 8'd60, 22'h2468AC);
        in_b = pk(0, 8'd61, 22'h13579B);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_value("stall_valid",  64'(out_valid), 1);
            check_value("stall_ready",  64'(in_ready), 0);
            check_value("stall_mant_a", 64'(out_mant_a), 64'(e1.mant_a));
            check_value("stall_mant_b", 64'(out_mant_b), 64'(e1.mant_b));
            tick();
        end
        n0 = n_out;
        out_ready = 1'b1;
        #1;
        check_value("release_in_ready", 64'(in_ready), 1);
        tick();
        in_a = pk(1, 8'd77, 22'h0F0F0F);
        in_b = pk(1, 8'd200, 22'h000001);
        check_value("stream_valid_1", 64'(out_valid), 1);
        tick();
        in_valid = 1'b0;
        check_value("stream_valid_2", 64'(out_valid), 1);
        tick();
        check_value("stream_valid_3", 64'(out_valid), 1);
        tick();
        check_value("stream_empty", 64'(out_valid), 0);
        check_value("stream_count", 64'(n_out - n0), 4);
        check_value("sb_empty", 64'(sb.size()), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(pk(0, 8'd10, 22'h1), pk(0, 8'd20, 22'h2));
        send(pk(0, 8'd30, 22'h3), pk(0, 8'd40, 22'h4));
        check_value("pre_rst_valid", 64'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_valid",  64'(out_valid), 0);
        check_value("async_rst_mant_a", 64'(out_mant_a), 0);
        check_value("async_rst_exp",    64'(out_exp_max), 0);
        tick();
        rst_n = 1'b1;
        check_value("post_rst_in_ready", 64'(in_ready), 1);
        check_value("post_rst_valid",    64'(out_valid), 0);
        out_ready = 1'b1;
        in_a = pk(1, 8'd131, 22'h2AAAAA);
        in_b = pk(0, 8'd129, 22'h155555);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_value("lat_cycle1", 64'(out_valid), 0);
        tick();
        check_value("lat_cycle2", 64'(out_valid), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pre_mant_aligner.md
Name: pre_mant_aligner

Overview:
- Front-end of the FP adder. It is the opposite end of the datapath from the post-add mantissa normaliser.
- Accepts two packed operands, unpacks them, and inserts the hidden bit.
- Picks the larger effective exponent, then right-aligns the smaller operand's significand into the 50-bit field consumed by the adder and normaliser.
- 2-stage pipeline with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent width.
- MANT_W, 22, stored fraction width.
- FIELD_W, 50, aligned mantissa field width. Hidden bit sits at FIELD_W-2; bit FIELD_W-1 is carry headroom.

Ports:
- clk  in  1  clock. One clock domain.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  31  operand A = {sign[30], exp[29:22], frac[21:0]}.
- in_b  in  31  operand B, same packing.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign_a  out  1  sign of A.
- out_sign_b  out  1  sign of B.
- out_mant_a  out  50  aligned magnitude of A.
- out_mant_b  out  50  aligned magnitude of B.
- out_exp_max  out  8  larger effective exponent.

Behaviour:
- Reset (async, rst_n=0): both stage valid flags, out_valid, all out_* data = 0. in_ready = 1 after reset.
- Unpack, per operand:
  - exp!=0: significand = {1'b1, frac}, effective exp = exp.
  - exp==0: significand = {1'b0, frac}, effective exp = 1 (denormal/zero).
  - exp=255 gets no special handling (treated as normal).
- Significand placement: bits [48:26] of the 50-bit field; bit 49 = 0; bits [25:0] = 0 before shift.
- Stage 1 (registered):
  - Signs, both placed significands.
  - exp_max = max(eff_a, eff_b).
  - diff = |eff_a - eff_b| (8-bit unsigned).
  - sel flag = 1 when B is the smaller operand.
  - Equal exponents: diff = 0, neither operand shifted.
- Stage 2 (registered):
  - The smaller operand's field is logically shifted right by diff; the larger passes unchanged.
  - diff >= 50: shifted field = 0.
  - Lane order is preserved: out_mant_a always belongs to in_a, regardless of which is larger.
- Latency: 2 cycles from an accepted input to out_valid, with no stall.
- Throughput: 1 pair/cycle.
- Flow control:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = stage-1 load condition. Combinational from out_ready; no registered skid.
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stall: while out_valid=1 & out_ready=0, all out_* remain stable. With both stages full, in_ready=0.
- Simultaneous output transfer and input transfer: both stages advance in the same cycle; no bubble is inserted.
- Bubble: when stage 1 is empty and stage 2 advances, stage 2 valid clears. Data registers may hold stale values; only valid is meaningful.
- Reset mid-operation: in-flight pairs are discarded and outputs return to reset values.

Optional Feature:
- STICKY_EN, defined:
  - Stage 2 ORs every bit shifted out of the smaller operand's field into bit 0 of that shifted result.
  - diff >= 50 with a nonzero significand gives field = 50'h1.
- STICKY_EN, undefined:
  - Shifted-out bits are dropped and bit 0 is pure shift output.
  - No extra logic.

Test Plan:
1. A = {0,130,0}, B = {1,128,0}, out_ready=1.
   - 2 cycles later: out_mant_a = 50'h1000000000000, out_mant_b = 50'h0400000000000, out_exp_max = 130, out_sign_b = 1.
2. A = {0,0,22'h000001}, B = {0,0,22'h000001}.
   - Both out_mant = 50'h0000004000000, out_exp_max = 1 (denormal path, no shift).
3. A = {0,127,0}, B = {0,100,0} (diff 27).
   - out_mant_b = 50'h0000000200000.
   - Swap the operands: the same value appears on out_mant_a, with exp_max = 127.
4. A = {0,200,0}, B = {0,100,22'h3FFFFF} (diff 100).
   - out_mant_b = 0.
   - With STICKY_EN: out_mant_b = 50'h1.
   - Also check diff 48 vs 49 with B frac = 0: diff 48 gives out_mant_b = 1, diff 49 gives 0 (1 with STICKY_EN).
5. Stream 4 pairs with out_ready=0.
   - in_ready drops after 2 accepts; out_* are held stable.
   - Raise out_ready: results emerge in order, one per cycle, with none lost or duplicated.
6. Pull rst_n low while both stages are valid.
   - out_valid = 0 immediately (async).
   - After release: in_ready = 1, and the first new pair emerges 2 cycles after it is accepted.
